// File: rtl/hdr_strip_pkg.sv
// Shared types and helpers for the header stripper: FSM states, beat byte math.
package hdr_strip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_FLUSH
    } state_t;

    function automatic int calc_bpb(input int data_width);
        return data_width / 8;
    endfunction

    localparam int DEFAULT_BPB = calc_bpb(128);

    typedef logic [$clog2(DEFAULT_BPB+1)-1:0] byte_cnt_t;

    // Unused bytes at the LSB end of a beat holding valid_bytes bytes.
    function automatic int calc_empty(input int bpb, input int valid_bytes);
        return bpb - valid_bytes;
    endfunction

endpackage

// File: rtl/header_stripper_byte_realigner.sv
// Combinational byte realigner: merges the stored residual with an input beat at
// byte offset off and produces the next residual plus the beat's valid-byte count.
module byte_realigner
    import hdr_strip_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    localparam int BPB        = calc_bpb(DATA_WIDTH),
    localparam int EW         = $clog2(BPB),
    localparam int BCW        = $clog2(BPB + 1)
) (
    input  logic [DATA_WIDTH-1:0] resid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [EW-1:0]         off,
    input  logic                  in_eop,
    input  logic [EW-1:0]         in_empty,
    output logic [DATA_WIDTH-1:0] merged,
    output logic [DATA_WIDTH-1:0] next_resid,
    output logic [BCW-1:0]        valid_bytes
);

    // Residual sits MSB-aligned; the head of the new beat fills the bytes after it.
    always_comb begin
        merged = in_data;
        if (off != '0) begin
            merged = resid | (in_data >> ((BPB - int'(off)) * 8));
        end
        next_resid  = in_data << (int'(off) * 8);
        valid_bytes = in_eop ? BCW'(BPB - int'(in_empty)) : BCW'(BPB);
    end

endmodule

// File: rtl/header_stripper.sv
// Strips a runtime-sized header from an Avalon-ST stream, exports it, realigns payload.
// Optional HEADER_STRIP_STATS_EN adds pkt_cnt / drop_cnt statistics outputs.
module header_stripper
    import hdr_strip_pkg::*;
#(
    parameter  int DATA_WIDTH       = 128,
    parameter  int MAX_HEADER_BYTES = 64,
    localparam int BPB              = calc_bpb(DATA_WIDTH),
    localparam int EW               = $clog2(BPB),
    localparam int BCW              = $clog2(BPB + 1),
    localparam int HLW              = $clog2(MAX_HEADER_BYTES + 1),
    localparam int HW               = MAX_HEADER_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HLW-1:0]        header_len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [EW-1:0]         in_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [EW-1:0]         out_empty,
    output logic [HW-1:0]         header_data,
    output logic                  header_valid,
    output logic                  hdr_short_err
`ifdef HEADER_STRIP_STATS_EN
    ,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt
`endif
);

    state_t                state_q, state_d;
    logic [HLW-1:0]        h_q, h_d, cnt_q, cnt_d;
    logic [EW-1:0]         off_q, off_d, flush_empty_q, flush_empty_d;
    logic [HW-1:0]         header_q, header_d, hdr_fill;
    logic [DATA_WIDTH-1:0] resid_q, resid_d;
    logic                  first_q, first_d;
    logic                  hv_q, hv_d, se_q, se_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  ov_q, ov_d, os_q, os_d, oe_q, oe_d;
    logic [EW-1:0]         oem_q, oem_d;

    logic                  adv, fire, do_hdr;
    int                    sat_len, cur_h, cur_cnt, v_i;
    logic [EW-1:0]         cur_off;
    logic [DATA_WIDTH-1:0] merged, next_resid;
    logic [BCW-1:0]        valid_bytes;

    byte_realigner #(.DATA_WIDTH(DATA_WIDTH)) u_realign (
        .resid       (resid_q),
        .in_data     (in_data),
        .off         (cur_off),
        .in_eop      (in_eop),
        .in_empty    (in_empty),
        .merged      (merged),
        .next_resid  (next_resid),
        .valid_bytes (valid_bytes)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            h_q           <= '0;
            cnt_q         <= '0;
            off_q         <= '0;
            flush_empty_q <= '0;
            header_q      <= '0;
            resid_q       <= '0;
            first_q       <= 1'b0;
            hv_q          <= 1'b0;
            se_q          <= 1'b0;
            od_q          <= '0;
            ov_q          <= 1'b0;
            os_q          <= 1'b0;
            oe_q          <= 1'b0;
            oem_q         <= '0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            cnt_q         <= cnt_d;
            off_q         <= off_d;
            flush_empty_q <= flush_empty_d;
            header_q      <= header_d;
            resid_q       <= resid_d;
            first_q       <= first_d;
            hv_q          <= hv_d;
            se_q          <= se_d;
            od_q          <= od_d;
            ov_q          <= ov_d;
            os_q          <= os_d;
            oe_q          <= oe_d;
            oem_q         <= oem_d;
        end
    end

    // In IDLE the header geometry comes straight from header_len on the SOP beat.
    always_comb begin
        sat_len = (int'(header_len) > MAX_HEADER_BYTES) ? MAX_HEADER_BYTES : int'(header_len);
        cur_h   = (state_q == ST_IDLE) ? sat_len : int'(h_q);
        cur_cnt = (state_q == ST_IDLE) ? 0 : int'(cnt_q);
        cur_off = EW'(cur_h % BPB);
        v_i     = int'(valid_bytes);
        do_hdr  = fire && (((state_q == ST_IDLE) && in_sop && (cur_h != 0)) ||
                           (state_q == ST_HEADER));
        hdr_fill = (state_q == ST_IDLE) ? '0 : header_q;
        for (int j = 0; j < MAX_HEADER_BYTES; j++) begin
            if ((j >= cur_cnt) && (j < cur_cnt + BPB) && (j < cur_h)) begin
                hdr_fill[HW-1-8*j -: 8] = in_data[DATA_WIDTH-1-8*(j-cur_cnt) -: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        cnt_d         = cnt_q;
        off_d         = off_q;
        flush_empty_d = flush_empty_q;
        header_d      = header_q;
        resid_d       = resid_q;
        first_d       = first_q;
        hv_d          = 1'b0;
        se_d          = 1'b0;
        ov_d          = ov_q;
        od_d          = od_q;
        os_d          = os_q;
        oe_d          = oe_q;
        oem_d         = oem_q;
        if (adv) begin
            ov_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (fire && in_sop) begin
                    h_d      = HLW'(cur_h);
                    off_d    = cur_off;
                    cnt_d    = '0;
                    header_d = hdr_fill;
                    resid_d  = '0;
                    first_d  = 1'b0;
                    if (cur_h == 0) begin
                        hv_d    = 1'b1;
                        ov_d    = 1'b1;
                        od_d    = in_data;
                        os_d    = 1'b1;
                        oe_d    = in_eop;
                        oem_d   = in_eop ? in_empty : '0;
                        state_d = in_eop ? ST_IDLE : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (fire) begin
                    ov_d    = 1'b1;
                    os_d    = first_q;
                    oe_d    = in_eop;
                    oem_d   = '0;
                    first_d = 1'b0;
                    resid_d = next_resid;
                    if (off_q == '0) begin
                        od_d = in_data;
                        if (in_eop) oem_d = in_empty;
                    end else begin
                        od_d = merged;
                        // Leftover bytes beyond one beat spill into the FLUSH beat.
                        if (in_eop && (v_i > int'(off_q))) begin
                            oe_d          = 1'b0;
                            flush_empty_d = EW'(calc_empty(BPB, v_i - int'(off_q)));
                        end else if (in_eop) begin
                            oem_d = EW'(int'(off_q) - v_i);
                        end
                    end
                    if (in_eop) begin
                        state_d = ((off_q != '0) && (v_i > int'(off_q))) ? ST_FLUSH : ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (adv) begin
                    ov_d    = 1'b1;
                    od_d    = resid_q;
                    os_d    = 1'b0;
                    oe_d    = 1'b1;
                    oem_d   = flush_empty_q;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (do_hdr) begin
            header_d = hdr_fill;
            if (cur_cnt + v_i < cur_h) begin
                if (in_eop) begin
                    se_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = HLW'(cur_cnt + BPB);
                    state_d = ST_HEADER;
                end
            end else begin
                hv_d = 1'b1;
                if (in_eop) begin
                    if (cur_cnt + v_i > cur_h) begin
                        ov_d  = 1'b1;
                        od_d  = next_resid;
                        os_d  = 1'b1;
                        oe_d  = 1'b1;
                        oem_d = EW'(calc_empty(BPB, cur_cnt + v_i - cur_h));
                    end
                    state_d = ST_IDLE;
                end else begin
                    resid_d = next_resid;
                    first_d = 1'b1;
                    state_d = ST_PAYLOAD;
                end
            end
        end
    end

    always_comb begin
        adv           = !ov_q || out_ready;
        in_ready      = !rst && (state_q != ST_FLUSH) && adv;
        fire          = in_valid && in_ready;
        out_data      = od_q;
        out_valid     = ov_q;
        out_sop       = os_q;
        out_eop       = oe_q;
        out_empty     = oem_q;
        header_data   = header_q;
        header_valid  = hv_q;
        hdr_short_err = se_q;
    end

`ifdef HEADER_STRIP_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + (hv_d ? 32'd1 : 32'd0);
        drop_cnt_d = drop_cnt_q + (se_d ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_header_stripper.sv
// Directed self-checking bench for header_stripper (DATA_WIDTH 128, MAX_HEADER_BYTES 64).
module tb_header_stripper;

    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } beat_t;

    logic         clk;
    logic         rst;
    logic [6:0]   header_len;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_sop;
    logic         in_eop;
    logic [3:0]   in_empty;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sop;
    logic         out_eop;
    logic [3:0]   out_empty;
    logic [511:0] header_data;
    logic         header_valid;
    logic         hdr_short_err;
`ifdef HEADER_STRIP_STATS_EN
    logic [31:0]  pkt_cnt;
    logic [31:0]  drop_cnt;
`endif

    int           n_vec;
    int           n_err;
    int           hv_count;
    int           se_count;
    int           ready_low;
    logic [511:0] hv_data;
    beat_t        obs[$];
    logic         rand_ready;
    logic         stall_pend;
    logic [134:0] stall_snap;

    header_stripper #(.DATA_WIDTH(128), .MAX_HEADER_BYTES(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .header_len    (header_len),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_empty      (in_empty),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_empty     (out_empty),
        .header_data   (header_data),
        .header_valid  (header_valid),
        .hdr_short_err (hdr_short_err)
`ifdef HEADER_STRIP_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Sink backpressure: held high except while the random-stall scenario runs.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Collects sink traffic and pulses; also checks the source holds while stalled.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                checkOutput("stall_hold",
                            512'({out_valid, out_sop, out_eop, out_empty, out_data}),
                            512'(stall_snap));
            end
            if (out_valid && out_ready) begin
                b.data  = out_data;
                b.sop   = out_sop;
                b.eop   = out_eop;
                b.empty = out_empty;
                obs.push_back(b);
            end
            stall_pend = out_valid && !out_ready;
            stall_snap = {out_valid, out_sop, out_eop, out_empty, out_data};
            if (header_valid) begin
                hv_count++;
                hv_data = header_data;
            end
            if (hdr_short_err) se_count++;
            if (!in_ready) ready_low++;
        end
    end

    function automatic logic [7:0] pat(input int id, input int k);
        return 8'(id * 29 + k * 7 + 3);
    endfunction

    function automatic logic [511:0] expHeader(input int id, input int h);
        logic [511:0] e;
        e = '0;
        for (int k = 0; k < h; k++) e[511-8*k -: 8] = pat(id, k);
        return e;
    endfunction

    task automatic sendBeat(input logic [127:0] d, input logic s, input logic e,
                            input logic [3:0] emp);
        int   waited;
        logic acc;
        waited   = 0;
        acc      = 1'b0;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = emp;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 200) begin
                checkOutput("accept_timeout", 512'(0), 512'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = '0;
    endtask

    task automatic applyStimulus(input int id, input int n, input int h, input int max_beats);
        int           nb;
        int           vb;
        logic [127:0] d;
        nb         = (n + 15) / 16;
        header_len = 7'(h);
        for (int b = 0; b < nb && b < max_beats; b++) begin
            d  = '0;
            vb = (n - 16 * b >= 16) ? 16 : n - 16 * b;
            for (int k = 0; k < vb; k++) d[127-8*k -: 8] = pat(id, 16 * b + k);
            sendBeat(d, b == 0, b == nb - 1, (b == nb - 1) ? 4'(16 - vb) : 4'd0);
        end
    endtask

    task automatic checkPacket(input int id, input int n, input int h, input int exp_beats,
                               input int exp_last_empty, input string tag);
        beat_t        b;
        logic [127:0] e;
        bit           last;
        for (int i = 0; i < exp_beats; i++) begin
            if (obs.size() == 0) begin
                checkOutput({tag, "_missing_beat"}, 512'(0), 512'(1));
                break;
            end
            b    = obs.pop_front();
            last = (i == exp_beats - 1);
            e    = '0;
            for (int k = 0; k < 16; k++) begin
                if (h + 16 * i + k < n) e[127-8*k -: 8] = pat(id, h + 16 * i + k);
            end
            checkOutput({tag, "_data"}, 512'(b.data), 512'(e));
            checkOutput({tag, "_sop"}, 512'(b.sop), 512'(i == 0));
            checkOutput({tag, "_eop"}, 512'(b.eop), 512'(last));
            checkOutput({tag, "_empty"}, 512'(b.empty), last ? 512'(exp_last_empty) : 512'(0));
        end
    endtask

    task automatic clearObs();
        obs.delete();
        hv_count  = 0;
        se_count  = 0;
        ready_low = 0;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] d;
        int           eops;
        n_vec      = 0;
        n_err      = 0;
        hv_count   = 0;
        se_count   = 0;
        ready_low  = 0;
        hv_data    = '0;
        rand_ready = 1'b0;
        stall_pend = 1'b0;
        stall_snap = '0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        in_empty   = '0;
        header_len = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 512'(in_ready), 512'(0));
        checkOutput("rst_out_valid", 512'(out_valid), 512'(0));
        checkOutput("rst_header_valid", 512'(header_valid), 512'(0));
        checkOutput("rst_header_data", header_data, 512'(0));
        checkOutput("rst_short_err", 512'(hdr_short_err), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] scenario 1: 32-byte header, 64-byte packet");
        clearObs();
        applyStimulus(1, 64, 32, 99);
        drain();
        checkOutput("s1_beats", 512'(obs.size()), 512'(2));
        checkOutput("s1_hv_count", 512'(hv_count), 512'(1));
        checkOutput("s1_header", hv_data, expHeader(1, 32));
        checkPacket(1, 64, 32, 2, 0, "s1");

        $display("[TB] scenario 2: 20-byte header, 50-byte packet");
        clearObs();
        applyStimulus(2, 50, 20, 99);
        drain();
        checkOutput("s2_beats", 512'(obs.size()), 512'(2));
        checkOutput("s2_hv_count", 512'(hv_count), 512'(1));
        checkOutput("s2_header", hv_data, expHeader(2, 20));
        checkPacket(2, 50, 20, 2, 2, "s2");

        $display("[TB] scenario 3: 20-byte header, 60-byte packet with flush beat");
        clearObs();
        applyStimulus(3, 60, 20, 99);
        drain();
        checkOutput("s3_beats", 512'(obs.size()), 512'(3));
        checkOutput("s3_ready_low_cycles", 512'(ready_low), 512'(1));
        checkOutput("s3_hv_count", 512'(hv_count), 512'(1));
        checkPacket(3, 60, 20, 3, 8, "s3");

        $display("[TB] scenario 4: 32-byte header, 24-byte packet");
        clearObs();
        applyStimulus(4, 24, 32, 99);
        drain();
        checkOutput("s4_beats", 512'(obs.size()), 512'(0));
        checkOutput("s4_short_err_count", 512'(se_count), 512'(1));
        checkOutput("s4_hv_count", 512'(hv_count), 512'(0));
`ifdef HEADER_STRIP_STATS_EN
        checkOutput("s4_drop_cnt", 512'(drop_cnt), 512'(1));
        checkOutput("s4_pkt_cnt", 512'(pkt_cnt), 512'(3));
`endif

        $display("[TB] scenario 5: ten back-to-back flush packets with random backpressure");
        clearObs();
        rand_ready = 1'b1;
        for (int p = 0; p < 10; p++) applyStimulus(10 + p, 60, 20, 99);
        for (int c = 0; c < 400 && obs.size() < 30; c++) @(posedge clk);
        rand_ready = 1'b0;
        drain();
        checkOutput("s5_beats", 512'(obs.size()), 512'(30));
        checkOutput("s5_hv_count", 512'(hv_count), 512'(10));
        for (int p = 0; p < 10; p++) checkPacket(10 + p, 60, 20, 3, 8, "s5");

        $display("[TB] scenario 6: reset mid-payload, then zero-length header packet");
        clearObs();
        applyStimulus(6, 50, 20, 3);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("s6_rst_out_valid", 512'(out_valid), 512'(0));
        eops = 0;
        foreach (obs[i]) if (obs[i].eop) eops++;
        checkOutput("s6_pre_reset_eops", 512'(eops), 512'(0));
        clearObs();
        hv_data = '1;
        d = '0;
        d[127 -: 8] = pat(6, 48);
        d[119 -: 8] = pat(6, 49);
        sendBeat(d, 1'b0, 1'b1, 4'd14);
        applyStimulus(7, 40, 0, 99);
        drain();
        checkOutput("s6_beats", 512'(obs.size()), 512'(3));
        checkOutput("s6_hv_count", 512'(hv_count), 512'(1));
        checkOutput("s6_header", hv_data, 512'(0));
        checkPacket(7, 40, 0, 3, 8, "s6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/header_stripper.md
# header_stripper

Parametrised successor to the fixed header remover. Strips a per-packet, runtime-selected header of 0..MAX_HEADER_BYTES bytes from an Avalon-ST packet stream, exports it as a captured header vector, and realigns the payload to beat boundaries. Header length need not be a multiple of the beat width. Sits between the packet ingress and the AES datapath.

## Interface

- DATA_WIDTH, 128: beat width in bits; multiple of 8; BPB = DATA_WIDTH/8.
- MAX_HEADER_BYTES, 64: largest supported header; header_len values above it saturate.
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous to clk, active-high.
- header_len  in  $clog2(MAX_HEADER_BYTES+1)  header size in bytes; sampled on the accepted SOP beat.
- in_data / in_valid / in_ready / in_sop / in_eop / in_empty  in,in,out,in,in,in  DATA_WIDTH,1,1,1,1,$clog2(BPB)  Avalon-ST sink.
- out_data / out_valid / out_ready / out_sop / out_eop / out_empty  out,out,in,out,out,out  same widths  Avalon-ST source.
- header_data  out  MAX_HEADER_BYTES*8  captured header; byte 0 at MSB; bytes at or beyond header_len are zero.
- header_valid  out  1  one-cycle pulse when header_data is complete.
- hdr_short_err  out  1  one-cycle pulse when EOP arrives before the header completes.

## Operation

- Byte order: byte 0 of a beat is data[DATA_WIDTH-1 -: 8]. Empty counts unused bytes at the LSB end, valid on EOP beats only.
- States: IDLE, HEADER, PAYLOAD, FLUSH.
- IDLE: beats without in_sop are accepted and discarded. SOP beat: latch H = min(header_len, MAX), OFF = H mod BPB, clear header_data. Go to HEADER, or to PAYLOAD if H = 0 (pass-through; header_valid pulses with header_data = 0).
- HEADER: header bytes are shifted into header_data, and no output is produced. On the beat containing the last header byte, header_valid pulses and the BPB-OFF trailing bytes are stored in the residual register. If that beat is also EOP, bytes beyond H form the whole payload; an empty payload produces no output. Then go to PAYLOAD, or to IDLE if EOP.
- EOP in HEADER before H bytes: drop the packet, pulse hdr_short_err, do not pulse header_valid, and go to IDLE.
- PAYLOAD, OFF = 0: beats are passed unchanged.
- PAYLOAD, OFF > 0: each output beat is residual (BPB-OFF bytes) followed by the first OFF bytes of the input; the remaining input bytes become the new residual.
- EOP beat with V = BPB - in_empty valid bytes:
  - V ≤ OFF: the final beat carries out_empty = OFF - V; go to IDLE.
  - V > OFF: emit a full beat, then enter FLUSH and emit a residual-only beat with out_empty = BPB - (V - OFF); go to IDLE.
- out_sop is set on the first payload beat emitted.
- in_sop outside IDLE is ignored, and the beat is treated as data.

## Timing

- Reset values: all outputs 0, state IDLE, header_data 0, residual 0. in_ready is 0 during reset.
- Output registered: a payload beat appears one cycle after the accepting input edge. header_valid rises one cycle after the last header beat is accepted.
- in_ready = !rst && state != FLUSH && (!out_valid || out_ready).
- out_* are held stable while out_valid && !out_ready.
- FLUSH costs exactly one extra output cycle, with in_ready = 0.
- Throughput is 1 beat/cycle with out_ready held high.
- Header beats consume input with no output bubbles on the sink.
- Reset mid-packet: the partial packet is lost with no EOP emitted. Post-reset beats without SOP are discarded.

## Configuration

- HEADER_STRIP_STATS_EN defined: adds outputs pkt_cnt[31:0] and drop_cnt[31:0].
  - pkt_cnt increments on each completed header_valid.
  - drop_cnt increments on hdr_short_err.
  - Both counters wrap at 2^32 and are cleared by rst.
- HEADER_STRIP_STATS_EN undefined: these ports and counters are absent.
- Core behaviour is identical in both builds.

## Structure

- hdr_strip_pkg holds:
  - the state enum;
  - the BPB localparam function;
  - the byte-count typedef sized $clog2(BPB+1);
  - the empty-computation function.
- Sub-module byte_realigner is combinational: it merges residual and input at byte offset OFF and computes the next residual and valid-byte count. The FSM, header capture and output register stay in header_stripper.

## Test plan

All scenarios use DATA_WIDTH = 128 (BPB = 16).

1. header_len = 32, 64-byte packet (4 full beats) -> header_valid after beat 2; 2 output beats (payload bytes 32..63); SOP on the first, EOP on the second with empty 0.
2. header_len = 20, 50-byte packet (last beat empty 14) -> output 2 beats: bytes 20..35, then bytes 36..49 with EOP and empty 2; header_data bytes 0..19 match, bytes 20..63 are zero.
3. header_len = 20, 60-byte packet (last beat empty 4) -> 3 output beats: 16, 16, then 8 bytes with empty 8 (the FLUSH beat); in_ready low for that one cycle.
4. header_len = 32, 24-byte packet -> no output beats; hdr_short_err pulses once; header_valid stays low. With the macro defined, drop_cnt = 1.
5. Scenario 3 repeated back-to-back ten times with out_ready random at 50% -> byte-exact output with no duplication or loss; out_* stable while stalled.
6. rst asserted during the PAYLOAD of scenario 2, then a header_len = 0 packet of 40 bytes -> no stray EOP; output identical to the input beats, with header_valid pulsing and header_data = 0.
